// File: rtl/pilot_cond_pkg.sv
// Shared constants and helpers for the pilot input conditioner.
// Optional glitch statistics are enabled with PILOT_COND_GLITCH_CNT_EN.
package pilot_cond_pkg;

  localparam int unsigned PILOT_N_IN        = 27;
  localparam int unsigned PILOT_SYNC_STAGES = 2;
  localparam int unsigned PILOT_DEB_CYCLES  = 4;
  localparam int unsigned GLITCH_W          = 8;

  // Ceiling log2; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pilot_debounce_bit.sv
// One input bit: synchronizer chain followed by a persistence debouncer.
// The glitch flag exists only when PILOT_COND_GLITCH_CNT_EN is defined.
module pilot_debounce_bit
  import pilot_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = PILOT_SYNC_STAGES,
  parameter int unsigned DEB_CYCLES  = PILOT_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic x_raw,
  output logic cond,
  output logic settled_c,
`ifdef PILOT_COND_GLITCH_CNT_EN
  output logic glitch_c,
`endif
  output logic flip_c
);

  localparam int unsigned CNT_W = clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   cond_d;
  logic                   rejected;

  assign syn = sync_q[SYNC_STAGES-1];

  // Synchronizer shifts every cycle, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], x_raw};
  end

  // Debounce next-state: restart on agreement, accept after DEB_CYCLES of disagreement.
  always_comb begin
    cnt_d    = cnt_q;
    cond_d   = cond;
    rejected = 1'b0;
    flip_c   = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (syn == cond) begin
      cnt_d    = '0;
      rejected = (cnt_q != '0);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      cond_d = syn;
      flip_c = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cond  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cond  <= cond_d;
    end
  end

  assign settled_c = (syn == cond) && (cnt_q == '0);

`ifdef PILOT_COND_GLITCH_CNT_EN
  assign glitch_c = rejected;
`endif

endmodule

// File: rtl/pilot_input_conditioner.sv
// Synchronizes and debounces the raw x1..x27 bundle for the pilot FSM.
// Define PILOT_COND_GLITCH_CNT_EN to add glitch_cnt / clr_stats.
module pilot_input_conditioner
  import pilot_cond_pkg::*;
#(
  parameter int unsigned N_IN        = PILOT_N_IN,
  parameter int unsigned SYNC_STAGES = PILOT_SYNC_STAGES,
  parameter int unsigned DEB_CYCLES  = PILOT_DEB_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_IN-1:0] x_raw,
  output logic [N_IN-1:0] x_cond,
  output logic            x_changed,
  output logic            stable
`ifdef PILOT_COND_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt,
  input  logic                clr_stats
`endif
);

  logic [N_IN-1:0] settled;
  logic [N_IN-1:0] flip;
`ifdef PILOT_COND_GLITCH_CNT_EN
  logic [N_IN-1:0] glitch;
`endif

  // One conditioning slice per input bit.
  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    pilot_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .x_raw     (x_raw[i]),
      .cond      (x_cond[i]),
      .settled_c (settled[i]),
`ifdef PILOT_COND_GLITCH_CNT_EN
      .glitch_c  (glitch[i]),
`endif
      .flip_c    (flip[i])
    );
  end

  // Change pulse coincides with the x_cond update; stable reflects all bits idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_changed <= 1'b0;
      stable    <= 1'b0;
    end else begin
      x_changed <= |flip;
      stable    <= &settled;
    end
  end

`ifdef PILOT_COND_GLITCH_CNT_EN
  // Saturating per-edge glitch count; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (clr_stats) begin
      glitch_cnt <= '0;
    end else if ((|glitch) && (glitch_cnt != {GLITCH_W{1'b1}})) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pilot_input_conditioner.sv
// Self-checking bench for pilot_input_conditioner (default parameters).
// Glitch statistics checks are built when PILOT_COND_GLITCH_CNT_EN is defined.
module tb_pilot_input_conditioner;

  logic        clk;
  logic        rst;
  logic        en;
  logic [26:0] x_raw;
  logic [26:0] x_cond;
  logic        x_changed;
  logic        stable;
`ifdef PILOT_COND_GLITCH_CNT_EN
  logic [7:0]  glitch_cnt;
  logic        clr_stats;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned due;
    logic [26:0] val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [26:0] x;
    int unsigned hold;
    logic [26:0] exp;
    logic        chg;
  } vec_t;
  vec_t tbl[10];

  pilot_input_conditioner dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .x_raw     (x_raw),
    .x_cond    (x_cond),
    .x_changed (x_changed),
    .stable    (stable)
`ifdef PILOT_COND_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt),
    .clr_stats (clr_stats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every x_changed pulse must match the next expected update.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (x_changed) begin
        if (sbq.size() == 0) begin
          chk("spurious_x_changed", 32'(x_cond), 32'hFFFFFFFF);
        end else begin
          e = sbq.pop_front();
          chk("change_cycle", cyc, e.due);
          chk("change_value", 32'(x_cond), 32'(e.val));
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
        e = sbq.pop_front();
        chk("missing_x_changed", cyc, 32'hFFFFFFFF);
      end
    end
  end

  task automatic push_exp(input int unsigned due, input logic [26:0] val);
    exp_t e;
    e.due = due;
    e.val = val;
    sbq.push_back(e);
  endtask

  initial begin
    int unsigned c;
    logic [6:0]  pat;

    tbl[0] = '{27'h0000010, 8, 27'h0000010, 1'b1};
    tbl[1] = '{27'h0000410, 3, 27'h0000010, 1'b0};
    tbl[2] = '{27'h0000010, 8, 27'h0000010, 1'b0};
    tbl[3] = '{27'h4010011, 8, 27'h4010011, 1'b1};
    tbl[4] = '{27'h0000000, 8, 27'h0000000, 1'b1};
    tbl[5] = '{27'h2AAAAAA, 8, 27'h2AAAAAA, 1'b1};
    tbl[6] = '{27'h5555555, 2, 27'h2AAAAAA, 1'b0};
    tbl[7] = '{27'h2AAAAAA, 8, 27'h2AAAAAA, 1'b0};
    tbl[8] = '{27'h7FFFFFF, 4, 27'h7FFFFFF, 1'b1};
    tbl[9] = '{27'h0000000, 8, 27'h0000000, 1'b1};

    rst   = 1'b1;
    en    = 1'b1;
    x_raw = '0;
`ifdef PILOT_COND_GLITCH_CNT_EN
    clr_stats = 1'b0;
`endif

    // Reset and idle.
    repeat (3) @(negedge clk);
    chk("rst_x_cond", 32'(x_cond), 32'h0);
    chk("rst_x_changed", 32'(x_changed), 32'h0);
    chk("rst_stable", 32'(stable), 32'h0);
`ifdef PILOT_COND_GLITCH_CNT_EN
    chk("rst_glitch_cnt", 32'(glitch_cnt), 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("stable_after_release", 32'(stable), 32'h1);

    // Table-driven steps and glitches.
    for (int i = 0; i < 10; i++) begin
      x_raw = tbl[i].x;
      if (tbl[i].chg) push_exp(cyc + 6, tbl[i].exp);
      repeat (tbl[i].hold) @(negedge clk);
      if (tbl[i].hold >= 7) begin
        chk($sformatf("vec%0d_x_cond", i), 32'(x_cond), 32'(tbl[i].exp));
        chk($sformatf("vec%0d_stable", i), 32'(stable), 32'h1);
      end
    end
`ifdef PILOT_COND_GLITCH_CNT_EN
    chk("glitch_cnt_table", 32'(glitch_cnt), 32'd2);
`endif

    // Clean step on bit 5: stable profile and latency.
    pat   = 7'b1000011;
    c     = cyc;
    x_raw = x_raw | 27'h0000020;
    push_exp(c + 6, 27'h0000020);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk($sformatf("step_stable_k%0d", i - 1), 32'(stable), 32'(pat[i-1]));
      if (i == 5) chk("step_bit5_early", 32'(x_cond[5]), 32'h0);
      if (i == 6) chk("step_bit5_late", 32'(x_cond[5]), 32'h1);
    end
    @(negedge clk);

    // en dropped mid-count on bit 7, then restored.
    c     = cyc;
    x_raw = x_raw | 27'h0000080;
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("en_low_hold", 32'(x_cond), 32'h0000020);
    en = 1'b1;
    push_exp(c + 12, 27'h00000A0);
    repeat (3) @(negedge clk);
    chk("en_restart_early", 32'(x_cond[7]), 32'h0);
    @(negedge clk);
    chk("en_restart_flip", 32'(x_cond[7]), 32'h1);
    repeat (3) @(negedge clk);

`ifdef PILOT_COND_GLITCH_CNT_EN
    // 300 single-cycle glitches on bit 10 saturate the counter.
    for (int i = 0; i < 300; i++) begin
      x_raw[10] = 1'b1;
      @(negedge clk);
      x_raw[10] = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("glitch_cnt_sat", 32'(glitch_cnt), 32'd255);

    // clr_stats on the same edge as a glitch.
    x_raw[10] = 1'b1;
    @(negedge clk);
    x_raw[10] = 1'b0;
    repeat (2) @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("glitch_cnt_clr_wins", 32'(glitch_cnt), 32'd0);
    x_raw[10] = 1'b1;
    @(negedge clk);
    x_raw[10] = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_cnt_after_clr", 32'(glitch_cnt), 32'd1);
`endif

    // Async reset mid-debounce discards the pending change.
    x_raw = x_raw | 27'h0000008;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_x_cond", 32'(x_cond), 32'h0);
    chk("async_rst_stable", 32'(stable), 32'h0);
    chk("async_rst_x_changed", 32'(x_changed), 32'h0);
`ifdef PILOT_COND_GLITCH_CNT_EN
    chk("async_rst_glitch_cnt", 32'(glitch_cnt), 32'h0);
`endif
    x_raw = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_x_cond", 32'(x_cond), 32'h0);
    chk("post_rst_stable", 32'(stable), 32'h1);
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pilot_input_conditioner.md
Name: pilot_input_conditioner

Overview:
Upstream conditioning stage for the pilot control FSM. Takes the raw asynchronous sensor/condition inputs (x1..x27 bundle) and synchronizes each bit into clk. Debounces each bit and presents a glitch-free, registered vector to the FSM, plus change and stability indications. All outputs update only on posedge clk, so they are settled before the FSM samples on negedge clk.

Parameters:
N_IN, 27, number of conditioned input bits; bit i maps to FSM input x(i+1), with x23 slot unused and tied low by the integrator.
SYNC_STAGES, 2, flip-flops in each synchronizer chain; legal values are 2 or more.
DEB_CYCLES, 4, consecutive synchronized cycles a new level must persist before it is accepted; legal values are 1 or more.
CNT_W, derived as clog2(DEB_CYCLES)+1, width of each per-bit debounce counter.

Ports:
clk  in  1  clock; posedge active.
rst  in  1  reset, asynchronous, active-high.
en  in  1  debounce enable; when low, x_cond is frozen.
x_raw  in  N_IN  raw asynchronous inputs.
x_cond  out  N_IN  debounced, registered inputs to the FSM.
x_changed  out  1  one-cycle pulse when any x_cond bit changes.
stable  out  1  high when every bit is settled.
glitch_cnt  out  8  saturating count of rejected glitches (PILOT_COND_GLITCH_CNT_EN only).
clr_stats  in  1  synchronous clear of glitch_cnt (PILOT_COND_GLITCH_CNT_EN only).

Behaviour:
- Reset (rst=1, async): all sync flops 0, all counters 0, x_cond=0, x_changed=0, stable=0, glitch_cnt=0. Asserting rst mid-debounce discards the pending change.
- Sync: the chain for bit i shifts x_raw[i] on every posedge regardless of en. syn[i] is the last stage.
- Debounce, per bit, at each posedge with en=1:
  - If syn[i]==x_cond[i]: cnt<=0. If cnt was nonzero, this is a rejected glitch.
  - Else if cnt==DEB_CYCLES-1: x_cond[i]<=syn[i] and cnt<=0.
  - Else: cnt<=cnt+1.
- en=0: all counters are forced to 0 and x_cond holds. No glitches are counted. When en returns high, counting restarts from 0.
- Latency: a clean step first sampled at posedge k appears on x_cond after posedge k+SYNC_STAGES+DEB_CYCLES-1. With the defaults, that is the 6th edge inclusive of k.
- Rejection: a pulse lasting fewer than DEB_CYCLES synchronized cycles never reaches x_cond.
- DEB_CYCLES=1: x_cond follows syn with a one-cycle register delay.
- x_changed: registered; high for exactly the cycle in which x_cond differs from its previous value. Several bits changing at the same edge produce a single pulse.
- stable: registered; high when syn==x_cond and all cnt==0 for every bit. It is low from reset until the first such cycle after reset release.
- glitch_cnt: increments by 1 per edge if one or more bits reject a glitch at that edge (one count per edge, not per bit). It saturates at 255. If clr_stats and a glitch occur on the same edge, clr_stats wins and the result is 0.

Optional Feature:
PILOT_COND_GLITCH_CNT_EN:
- Defined: the glitch_cnt output and clr_stats input exist, with the counter behaviour above.
- Undefined: both ports and the counter logic are absent. All other behaviour is identical.

Decomposition:
- Package pilot_cond_pkg holds:
  - default constants PILOT_N_IN=27, PILOT_SYNC_STAGES=2, PILOT_DEB_CYCLES=4;
  - GLITCH_W=8;
  - a clog2 width function.
- Sub-module pilot_debounce_bit contains one synchronizer chain and one debounce counter. It outputs cond, settled and glitch. The top instantiates it N_IN times in a generate loop and ORs or reduces the per-bit flags.

Test Plan:
- Reset then idle: rst high for 3 cycles, x_raw=0 → all outputs 0; stable rises 1 cycle after release.
- Clean step: x_raw[4] 0→1 before posedge k, held → x_cond[4]=1 after posedge k+5; x_changed high for exactly that cycle; stable low from k+2 to k+5.
- Glitch: x_raw[10] high for 3 cycles, then low → x_cond unchanged; glitch_cnt increments 0→1.
- Simultaneous: bits 0, 16 and 26 step together → all three flip on the same edge; one x_changed pulse.
- en=0 during a pending change, then en=1 → x_cond holds while en is low; the flip occurs DEB_CYCLES edges after en returns.
- Saturation and clear: 300 glitches → glitch_cnt=255. A glitch on the same edge as clr_stats → glitch_cnt=0. Async rst mid-count clears everything immediately.
